// File: rtl/counter_ctrl_pkg.sv
// Shared types and default widths for the counter sweep sequencer.
package counter_ctrl_pkg;

  localparam int unsigned DEF_WIDTH    = 8;
  localparam int unsigned DEF_SWEEPS_W = 8;

  typedef enum logic [1:0] {
    MODE_UP       = 2'd0,
    MODE_DOWN     = 2'd1,
    MODE_PINGPONG = 2'd2
  } mode_e;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_SEEK = 3'd1,
    S_UP   = 3'd2,
    S_DOWN = 3'd3,
    S_DONE = 3'd4
  } state_e;

endpackage

// File: rtl/counter_sweep_ctrl.sv
// Sequences a free-running up/down counter through lo..hi sweeps using its
// direction and synchronous reset, one decision per clock.
module counter_sweep_ctrl
  import counter_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH    = DEF_WIDTH,
  parameter int unsigned SWEEPS_W = DEF_SWEEPS_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [WIDTH-1:0]    cmd_lo,
  input  logic [WIDTH-1:0]    cmd_hi,
  input  logic [1:0]          cmd_mode,
  input  logic [SWEEPS_W-1:0] cmd_sweeps,
  input  logic                abort,
  input  logic [WIDTH-1:0]    cnt_value,
  output logic                cnt_up_down,
  output logic                cnt_rst,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [SWEEPS_W-1:0] sweep_cnt
);

  state_e              state_q, state_d;
  state_e              act;
  mode_e               mode_q, mode_d;
  logic [WIDTH-1:0]    lo_q, lo_d, hi_q, hi_d, seek_tgt;
  logic [SWEEPS_W-1:0] sweeps_q, sweeps_d, sweep_q, sweep_d, sweep_inc;
  logic                done_q, done_d, err_q, err_d, last_sweep, illegal;

  // State and command latch
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      mode_q   <= MODE_UP;
      lo_q     <= '0;
      hi_q     <= '0;
      sweeps_q <= '0;
      sweep_q  <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      lo_q     <= lo_d;
      hi_q     <= hi_d;
      sweeps_q <= sweeps_d;
      sweep_q  <= sweep_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  // Next state and counter steering; SEEK on target behaves as the sweep state
  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    lo_d        = lo_q;
    hi_d        = hi_q;
    sweeps_d    = sweeps_q;
    sweep_d     = sweep_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    cnt_rst     = 1'b1;
    cnt_up_down = 1'b1;

    illegal    = (cmd_lo >= cmd_hi) || (cmd_sweeps == '0) || (cmd_mode == 2'd3);
    seek_tgt   = (mode_q == MODE_DOWN) ? hi_q : lo_q;
    last_sweep = (sweep_q == sweeps_q - SWEEPS_W'(1));
    sweep_inc  = (sweep_q == '1) ? sweep_q : sweep_q + SWEEPS_W'(1);
    act        = state_q;
    if (state_q == S_SEEK && cnt_value == seek_tgt)
      act = (mode_q == MODE_DOWN) ? S_DOWN : S_UP;

    if (abort && (state_q inside {S_SEEK, S_UP, S_DOWN})) begin
      state_d = S_IDLE;
    end else begin
      case (act)
        S_IDLE: begin
          if (cmd_valid) begin
            if (illegal) begin
              err_d = 1'b1;
            end else begin
              lo_d     = cmd_lo;
              hi_d     = cmd_hi;
              mode_d   = mode_e'(cmd_mode);
              sweeps_d = cmd_sweeps;
              sweep_d  = '0;
              state_d  = S_SEEK;
            end
          end
        end
        S_SEEK: cnt_rst = 1'b0;
        S_UP: begin
          if (cnt_value != hi_q) begin
            cnt_rst = 1'b0;
            state_d = S_UP;
          end else begin
            sweep_d = sweep_inc;
            if (last_sweep) begin
              done_d  = 1'b1;
              state_d = S_DONE;
            end else if (mode_q == MODE_PINGPONG) begin
              cnt_rst     = 1'b0;
              cnt_up_down = 1'b0;
              state_d     = S_DOWN;
            end else begin
              state_d = S_SEEK;
            end
          end
        end
        S_DOWN: begin
          if (cnt_value != lo_q) begin
            cnt_rst     = 1'b0;
            cnt_up_down = 1'b0;
            state_d     = S_DOWN;
          end else begin
            sweep_d = sweep_inc;
            if (last_sweep) begin
              done_d  = 1'b1;
              state_d = S_DONE;
            end else if (mode_q == MODE_PINGPONG) begin
              cnt_rst = 1'b0;
              state_d = S_UP;
            end else begin
              state_d = S_SEEK;
            end
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign cmd_ready = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;
  assign err       = err_q;
  assign sweep_cnt = sweep_q;

endmodule

// File: doc/counter_sweep_ctrl.md
Name: counter_sweep_ctrl

Overview:
Sequencer for the 8-bit up/down counter (ports cuenta/up_down/clk/rst, synchronous active-high rst, counts every clock). It accepts a sweep command over a valid/ready handshake. It then drives the counter's up_down and rst so the count walks between programmable bounds lo..hi in one of three modes. It reports progress and completion to the host. The counter has no enable, so this block must decide direction on every cycle and uses the counter's reset to park or restart it.

Parameters:
WIDTH, 8, counter/bound width; must match counter.
SWEEPS_W, 8, width of sweep count and progress counter.

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-low reset
cmd_valid  in  1  command offered
cmd_ready  out  1  block can accept a command (IDLE only)
cmd_lo  in  WIDTH  lower bound
cmd_hi  in  WIDTH  upper bound
cmd_mode  in  2  0=UP ramp, 1=DOWN ramp, 2=PINGPONG, 3=illegal
cmd_sweeps  in  SWEEPS_W  number of sweeps (legs) to run
abort  in  1  cancel running command
cnt_value  in  WIDTH  counter's cuenta
cnt_up_down  out  1  to counter up_down (1=+1)
cnt_rst  out  1  to counter rst (active-high, synchronous)
busy  out  1  state != IDLE
done  out  1  one-cycle completion pulse
err  out  1  one-cycle illegal-command pulse
sweep_cnt  out  SWEEPS_W  completed sweeps of current command

Behaviour:
- Reset (rst=0, async): state=IDLE; sweep_cnt=0, done=0, err=0, busy=0, cmd_ready=1, cnt_rst=1, cnt_up_down=1.
- States: IDLE, SEEK, UP, DOWN, DONE. State, latched command, sweep_cnt, done and err are registered. cnt_rst/cnt_up_down are combinational from state, latched command and cnt_value, because the counter moves on every edge.
- IDLE: cnt_rst=1, which holds the counter at 0. On cmd_valid&&cmd_ready, the command is checked:
  - Illegal if lo>=hi, or sweeps==0, or mode==3. An illegal command raises err the next cycle and the block stays in IDLE.
  - Otherwise lo/hi/mode/sweeps are latched, sweep_cnt is cleared and the next state is SEEK.
- SEEK: target = hi for DOWN, otherwise lo.
  - While cnt_value != target: cnt_rst=0, up_down=1.
  - When cnt_value == target: behave as the first cycle of the sweep state (DOWN mode -> DOWN state, else UP state), with that state's outputs applied this cycle.
- UP: cnt_rst=0, up_down=1 while cnt_value != hi. At cnt_value == hi (endpoint), the sweep completes and sweep_cnt increments:
  - Final sweep (sweep_cnt+1 == sweeps): cnt_rst=1, next state DONE.
  - PINGPONG: up_down=0, next state DOWN (no dwell: hi is followed by hi-1).
  - UP mode: cnt_rst=1, next state SEEK (restart from 0).
- DOWN: mirror of UP. up_down=0 while cnt_value != lo. At lo the sweep completes:
  - Final sweep: cnt_rst=1, next state DONE.
  - PINGPONG: up_down=1, next state UP.
  - DOWN mode: cnt_rst=1, next state SEEK.
- DONE: one cycle; done=1, cnt_rst=1, cmd_ready=0; next state IDLE.
- abort=1 in SEEK/UP/DOWN: cnt_rst=1 the same cycle, next state IDLE. No done pulse; sweep_cnt holds its value. abort is ignored in IDLE/DONE.
- Latency: command accepted at edge T -> SEEK from T+1 with counter 0 -> counter reaches lo at T+1+lo.
- lo==0: SEEK matches immediately on entry; no idle cycle.
- sweep_cnt saturates at its maximum; with sweeps != 0 it never exceeds sweeps.
- Reset mid-operation: immediate return to IDLE, counter parked via cnt_rst=1.

Decomposition:
- Package counter_ctrl_pkg holds:
  - mode enum (MODE_UP, MODE_DOWN, MODE_PINGPONG);
  - state enum (S_IDLE, S_SEEK, S_UP, S_DOWN, S_DONE);
  - default WIDTH/SWEEPS_W constants.
- No sub-module: a single FSM with a registered command latch. The bench instantiates the existing counter alongside it, with cnt_value wired back from cuenta.

Test Plan:
- UP, lo=3, hi=6, sweeps=1, accepted at T -> cnt_value 0,1,2,3,4,5,6 at T+1..T+7; done=1 at T+8 with cnt_value=0; sweep_cnt=1.
- PINGPONG, lo=2, hi=4, sweeps=3 -> post-seek sequence 2,3,4,3,2,3,4; sweep_cnt steps 1,2,3 at the values 4,2,4; done one cycle after the final 4.
- DOWN, lo=1, hi=3, sweeps=2 -> 0,1,2,3,2,1,0,1,2,3,2,1, then done; the 0 after the first 1 comes from cnt_rst.
- Illegal commands: lo=5,hi=5 then mode=3 -> err pulses once each; busy stays 0; cmd_ready stays 1; counter stays 0.
- Abort during PINGPONG at cnt_value=3 -> cnt_rst=1 that cycle, counter 0 next cycle, IDLE, no done.
- cmd_valid held high through DONE -> cmd_ready=0 in DONE; second command accepted in the following IDLE cycle. Async reset asserted mid-sweep -> all outputs at reset values immediately.
